// File: rtl/axi4_burst_fifo_if.sv
// Beat-level handshake bundle for axi4_burst_fifo: upstream (s_*) and downstream (m_*) channels.
// The slave modport is the FIFO's view; the master modport is the view of whatever drives it.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface axi4_burst_fifo_if #(
  parameter int DATA_W = `DATA_WIDTH + `DATA_WIDTH/8
);
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_valid;
  logic              m_ready;

  modport slave (
    input  s_data, s_last, s_valid, m_ready,
    output s_ready, m_data, m_last, m_valid
  );

  modport master (
    output s_data, s_last, s_valid, m_ready,
    input  s_ready, m_data, m_last, m_valid
  );
endinterface

// File: rtl/axi4_burst_fifo.sv
// Burst-aware beat FIFO with occupancy and complete-burst counters.
// Define AXI4_BURST_FIFO_STORE_FWD_EN to hold output until a whole burst (or a full buffer) is stored.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module axi4_burst_fifo #(
  parameter int DATA_W = `DATA_WIDTH + `DATA_WIDTH/8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  axi4_burst_fifo_if.slave bus,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] bursts
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W:0]  mem [DEPTH];
  logic [CNT_W-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic             ready_q, empty, full_nxt, push, pop, valid;

  assign empty    = (wr_ptr == rd_ptr);
  assign push     = bus.s_valid && ready_q;
  assign pop      = valid && bus.m_ready;
  assign wr_nxt   = wr_ptr + CNT_W'(push);
  assign rd_nxt   = rd_ptr + CNT_W'(pop);
  assign full_nxt = (wr_nxt[CNT_W-1] != rd_nxt[CNT_W-1]) &&
                    (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);

`ifdef AXI4_BURST_FIFO_STORE_FWD_EN
  logic full;
  assign full  = (wr_ptr[CNT_W-1] != rd_ptr[CNT_W-1]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // full escape lets a burst longer than the buffer drain instead of deadlocking
  assign valid = !empty && ((bursts != '0) || full);
`else
  assign valid = !empty;
`endif

  // ready is registered from next-state pointers, so it always equals !full after the first edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ready_q <= 1'b0;
      count   <= '0;
      bursts  <= '0;
    end else begin
      wr_ptr  <= wr_nxt;
      rd_ptr  <= rd_nxt;
      ready_q <= !full_nxt;
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      case ({push && bus.s_last, pop && bus.m_last})
        2'b10:   bursts <= bursts + CNT_W'(1);
        2'b01:   bursts <= bursts - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {bus.s_last, bus.s_data};
  end

  assign bus.s_ready             = ready_q;
  assign {bus.m_last, bus.m_data} = mem[rd_ptr[AW-1:0]];
  assign bus.m_valid             = valid;
endmodule
